alu_mc: RTL
===========

Name: alu_mc

Overview:
Parametrised, handshaked successor to the single-cycle combinational ALU.
- Registers every result together with a full flag set: zero, carry, signed overflow, negative.
- Adds multiply and set-less-than operations; multiply runs iteratively over WIDTH cycles.
- Sits between the register-read stage and writeback of the RISC-V datapath. Upstream/downstream stall through valid/ready.

Parameters:
WIDTH, 32, operand/result width in bits (power of two, >= 8)
SHAMT_W, $clog2(WIDTH), shift-amount bits taken from input_two

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operation request
in_ready  output  1  unit can accept a request this cycle
input_one  input  WIDTH  operand A
input_two  input  WIDTH  operand B / shift amount
func  input  4  operation code
out_valid  output  1  result registers hold an unconsumed result
out_ready  input  1  downstream consumes result this cycle
out  output  WIDTH  registered result
zeroflg  output  1  out == 0
cout  output  1  carry out (ADD/SUB only, else 0)
ovf  output  1  signed overflow (ADD/SUB only, else 0)
negflg  output  1  out[WIDTH-1]
busy  output  1  multiply in progress

Behaviour:
- Reset: one clock, synchronous, active-high. On rst=1 at a rising edge:
  - state=IDLE; out=0; out_valid=0.
  - zeroflg=1 (consistent with out=0); cout=0; ovf=0; negflg=0; busy=0.
  - Multiplier counter and accumulator cleared.
  - An in-flight multiply is aborted with no result produced.
- Func codes (shared package):
  - ADD 0000, SUB 0001, OR 0010, AND 0011.
  - SLL 0110, SRL 1111, SRA 1001.
  - XOR 1100, NOTA 1101.
  - NEW: MUL 0100, SLT 0101, SLTU 0111.
  - Any other code yields out=0, all flags zero except zeroflg=1, single-cycle.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Request accepted on an edge where in_valid && in_ready.
  - Result held stable (out and flags unchanged) while out_valid && !out_ready.
  - out_valid clears on the edge with out_ready=1 unless a new single-cycle result loads on that same edge; that load is allowed, giving back-to-back throughput of 1/cycle.
- Latency:
  - Single-cycle ops: accepted at edge t, out_valid=1 after edge t (visible cycle t+1).
  - MUL: accepted at edge t; state=MUL, busy=1, counter=WIDTH.
    - One multiplier bit per cycle (shift-add, LSB first).
    - Result (low WIDTH bits of the product) and out_valid load at edge t+WIDTH; busy drops at the same edge.
    - in_ready=0 throughout.
- Arithmetic:
  - ADD: {cout,out} = A+B.
  - SUB: computed as A + ~B + 1; cout = carry of that sum (1 means no borrow).
  - ovf, ADD: A and B share a sign and the result sign differs.
  - ovf, SUB: A and B differ in sign and the result sign differs from A.
  - SLT/SLTU: out = {WIDTH-1 zeros, signed/unsigned A<B}.
  - Shifts: amount = input_two[SHAMT_W-1:0]; upper bits ignored; SRA replicates A[WIDTH-1].
  - MUL is unsigned-by-unsigned, truncated to WIDTH bits; cout=ovf=0.
- Flags are computed from the registered result and always change together with out.
- Operands are captured at acceptance; input changes during MUL have no effect.

Decomposition:
- Package alu_pkg holds:
  - func code localparams (the 12 codes above);
  - shift-type constants SH_LL=2'b00, SH_LR=2'b01, SH_AR=2'b10;
  - state encoding IDLE/MUL.
- One combinational sub-module alu_shifter (parameter WIDTH) performs the barrel shift.
  - Ports: data in, shift amount, 2-bit type, data out.
  - Instantiated once, muxed by func.
- MUL sequencing, handshake and flag registers live in alu_mc.

Test Plan:
- ADD 0xFFFFFFFF+0x00000001, out_ready=1 -> next cycle out=0x00000000, zeroflg=1, cout=1, ovf=0, out_valid=1 for one cycle.
- SUB 0x80000000-0x00000001 -> out=0x7FFFFFFF, ovf=1, cout=1, negflg=0; then SLT 0xFFFFFFFF,0x00000001 -> out=1; SLTU on the same operands -> out=0 (back-to-back, one result per cycle).
- SRA 0x80000000 by input_two=0x00000024 (low 5 bits = 4) -> out=0xF8000000, negflg=1; SRL on the same operands -> 0x08000000.
- MUL 0x00010003 × 0x00000005 -> in_ready=0 and busy=1 for 32 cycles, out=0x0005000F with out_valid exactly 32 cycles after acceptance; in_valid pulses during MUL are not accepted.
- Backpressure: ADD 3+4 with out_ready=0 for 5 cycles -> out=7 held, in_ready=0, flags stable; raising out_ready together with a queued ADD 1+1 -> out=2 on the next cycle.
- rst asserted 10 cycles into a MUL -> next cycle out_valid=0, busy=0, out=0, zeroflg=1, in_ready=1; no stale product ever appears.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_mc shared definitions: func codes, shift types, state encoding.
// Imported by alu_shifter and alu_mc.
package alu_pkg;

  localparam logic [3:0] F_ADD  = 4'b0000;
  localparam logic [3:0] F_SUB  = 4'b0001;
  localparam logic [3:0] F_OR   = 4'b0010;
  localparam logic [3:0] F_AND  = 4'b0011;
  localparam logic [3:0] F_MUL  = 4'b0100;
  localparam logic [3:0] F_SLT  = 4'b0101;
  localparam logic [3:0] F_SLL  = 4'b0110;
  localparam logic [3:0] F_SLTU = 4'b0111;
  localparam logic [3:0] F_SRA  = 4'b1001;
  localparam logic [3:0] F_XOR  = 4'b1100;
  localparam logic [3:0] F_NOTA = 4'b1101;
  localparam logic [3:0] F_SRL  = 4'b1111;

  localparam logic [1:0] SH_LL = 2'b00;
  localparam logic [1:0] SH_LR = 2'b01;
  localparam logic [1:0] SH_AR = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter: din shifted by amt, kind per sh_type.
// Ports: din, amt, sh_type (SH_LL/SH_LR/SH_AR), dout.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   din,
  input  logic [SHAMT_W-1:0] amt,
  input  logic [1:0]         sh_type,
  output logic [WIDTH-1:0]   dout
);

  always_comb begin
    dout = '0;
    case (sh_type)
      SH_LL:   dout = din << amt;
      SH_LR:   dout = din >> amt;
      SH_AR:   dout = WIDTH'($signed(din) >>> amt);
      default: dout = '0;
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// Handshaked multi-cycle ALU with registered result and flags.
// Ports: clk, rst, in_valid/in_ready, input_one, input_two, func,
//        out_valid/out_ready, out, zeroflg, cout, ovf, negflg, busy.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_one,
  input  logic [WIDTH-1:0] input_two,
  input  logic [3:0]       func,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zeroflg,
  output logic             cout,
  output logic             ovf,
  output logic             negflg,
  output logic             busy
);

  localparam logic [SHAMT_W:0] CNT_INIT = (SHAMT_W+1)'(WIDTH);
  localparam logic [SHAMT_W:0] CNT_LAST = (SHAMT_W+1)'(1);

  state_e             state;
  logic [SHAMT_W:0]   cnt;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   prod_nxt;

  logic               sub;
  logic [WIDTH-1:0]   bop;
  logic [WIDTH:0]     sum;
  logic               add_ovf;
  logic [1:0]         sh_type;
  logic [WIDTH-1:0]   sh_out;
  logic [WIDTH-1:0]   res;
  logic               res_c;
  logic               res_v;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);

  // SUB reuses the adder as A + ~B + 1
  assign sub = (func == F_SUB);
  assign bop = sub ? ~input_two : input_two;
  assign sum = {1'b0, input_one} + {1'b0, bop}
             + (WIDTH+1)'(sub);
  assign add_ovf =
    (input_one[WIDTH-1] == bop[WIDTH-1]) &&
    (sum[WIDTH-1] != input_one[WIDTH-1]);

  always_comb begin
    sh_type = SH_LL;
    case (func)
      F_SRL:   sh_type = SH_LR;
      F_SRA:   sh_type = SH_AR;
      default: sh_type = SH_LL;
    endcase
  end

  alu_shifter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .din     (input_one),
    .amt     (input_two[SHAMT_W-1:0]),
    .sh_type (sh_type),
    .dout    (sh_out)
  );

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (func)
      F_ADD, F_SUB: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = add_ovf;
      end
      F_OR:   res = input_one | input_two;
      F_AND:  res = input_one & input_two;
      F_XOR:  res = input_one ^ input_two;
      F_NOTA: res = ~input_one;
      F_SLL, F_SRL, F_SRA: res = sh_out;
      F_SLT:
        res = WIDTH'($signed(input_one) < $signed(input_two));
      F_SLTU:
        res = WIDTH'(input_one < input_two);
      default: res = '0;
    endcase
  end

  // shift-add step, multiplier consumed LSB first
  assign prod_nxt = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out       <= '0;
      out_valid <= 1'b0;
      zeroflg   <= 1'b1;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      negflg    <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (func == F_MUL) begin
              state  <= MUL;
              busy   <= 1'b1;
              cnt    <= CNT_INIT;
              acc    <= '0;
              mcand  <= input_one;
              mplier <= input_two;
            end else begin
              out       <= res;
              cout      <= res_c;
              ovf       <= res_v;
              zeroflg   <= (res == '0);
              negflg    <= res[WIDTH-1];
              out_valid <= 1'b1;
            end
          end
        end
        MUL: begin
          acc    <= prod_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CNT_LAST;
          if (cnt == CNT_LAST) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out       <= prod_nxt;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zeroflg   <= (prod_nxt == '0);
            negflg    <= prod_nxt[WIDTH-1];
            out_valid <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
